// File: rtl/fcl1_act_streamer.sv
// Captures a 4-row staged frame and streams its 28 signed activations, one per handshake.
// Optional build macro FCL1_RELU_EN clamps negative activations to zero at load time.
module fcl1_act_streamer #(
    parameter int unsigned DW   = 16,
    parameter int unsigned EPR  = 7,
    parameter int unsigned ROWS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW*EPR-1:0]   in_FCL1_1,
    input  logic [DW*EPR-1:0]   in_FCL1_2,
    input  logic [DW*EPR-1:0]   in_FCL1_3,
    input  logic [DW*EPR-1:0]   in_FCL1_4,
    output logic [DW-1:0]       act_data,
    output logic                act_valid,
    input  logic                act_ready,
    output logic [4:0]          act_idx,
    output logic                act_last,
    output logic                frame_done,
    output logic                busy
);

    localparam int unsigned FW = DW * EPR * ROWS;
    localparam int unsigned N  = EPR * ROWS;
    localparam logic [4:0] LastIdx = 5'(N - 1);

    typedef enum logic {StIdle, StStream} state_e;

    state_e          r_state, w_state_d;
    logic [FW-1:0]   r_buf, w_buf_d;
    logic [4:0]      r_idx, w_idx_d;
    logic [DW-1:0]   r_data, w_data_d;
    logic            r_done, w_done_d;
    logic [FW-1:0]   w_frame_in;

    // Row 1 sits in the top bits so element 0 is the most significant slice.
    assign w_frame_in = {in_FCL1_1, in_FCL1_2, in_FCL1_3, in_FCL1_4};

    function automatic logic [DW-1:0] elem(input logic [FW-1:0] f, input logic [4:0] k);
        return f[FW - DW * (32'(k) + 1) +: DW];
    endfunction

    function automatic logic [DW-1:0] clamp(input logic [DW-1:0] e);
`ifdef FCL1_RELU_EN
        return e[DW-1] ? '0 : e;
`else
        return e;
`endif
    endfunction

    always_comb begin
        w_state_d = r_state;
        w_buf_d   = r_buf;
        w_idx_d   = r_idx;
        w_data_d  = r_data;
        w_done_d  = 1'b0;
        case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_buf_d   = w_frame_in;
                    w_idx_d   = '0;
                    w_data_d  = clamp(elem(w_frame_in, 5'd0));
                    w_state_d = StStream;
                end
            end
            StStream: begin
                if (act_ready) begin
                    if (r_idx == LastIdx) begin
                        w_idx_d   = '0;
                        w_data_d  = '0;
                        w_done_d  = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_idx_d  = r_idx + 5'd1;
                        w_data_d = clamp(elem(r_buf, r_idx + 5'd1));
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_buf   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_buf   <= w_buf_d;
            r_idx   <= w_idx_d;
            r_data  <= w_data_d;
            r_done  <= w_done_d;
        end
    end

    assign in_ready   = (r_state == StIdle);
    assign act_valid  = (r_state == StStream);
    assign busy       = (r_state == StStream);
    assign act_last   = (r_state == StStream) && (r_idx == LastIdx);
    assign act_data   = r_data;
    assign act_idx    = r_idx;
    assign frame_done = r_done;

endmodule

// File: tb/tb_fcl1_act_streamer.sv
// Scoreboard bench for fcl1_act_streamer: stimulus queues expected elements, a monitor checks them.
module tb_fcl1_act_streamer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [111:0] in_FCL1_1, in_FCL1_2, in_FCL1_3, in_FCL1_4;
    logic [15:0]  act_data;
    logic         act_valid;
    logic         act_ready;
    logic [4:0]   act_idx;
    logic         act_last;
    logic         frame_done;
    logic         busy;

    fcl1_act_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_FCL1_1  (in_FCL1_1),
        .in_FCL1_2  (in_FCL1_2),
        .in_FCL1_3  (in_FCL1_3),
        .in_FCL1_4  (in_FCL1_4),
        .act_data   (act_data),
        .act_valid  (act_valid),
        .act_ready  (act_ready),
        .act_idx    (act_idx),
        .act_last   (act_last),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [4:0]  i;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] vals[28];
    int          n_vec = 0;
    int          n_err = 0;
    logic        mon_en = 1'b0;
    logic        done_exp = 1'b0;
    logic        hold_q = 1'b0;
    logic [15:0] hold_d;
    logic [4:0]  hold_i;
    logic        hold_l;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] v);
`ifdef FCL1_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [447:0] pack_vals();
        logic [447:0] f;
        for (int k = 0; k < 28; k++) f[447-16*k -: 16] = vals[k];
        return f;
    endfunction

    task automatic drive_rows(input logic [447:0] f);
        in_FCL1_1 = f[447:336];
        in_FCL1_2 = f[335:224];
        in_FCL1_3 = f[223:112];
        in_FCL1_4 = f[111:0];
    endtask

    task automatic push_exp();
        for (int k = 0; k < 28; k++) exp_q.push_back({model(vals[k]), 5'(k), k == 27});
    endtask

    task automatic fill(input logic [15:0] base);
        for (int k = 0; k < 28; k++) vals[k] = base + 16'(k);
    endtask

    task automatic send_frame();
        drive_rows(pack_vals());
        push_exp();
        chk("in_ready_before_send", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating
    task automatic drain(input int mode, input int bound);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            act_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !act_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_complete", 32'(ok), 32'd1);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   32'd1);
        chk({tag, "_act_valid"},  32'(act_valid),  32'd0);
        chk({tag, "_act_data"},   32'(act_data),   32'd0);
        chk({tag, "_act_idx"},    32'(act_idx),    32'd0);
        chk({tag, "_act_last"},   32'(act_last),   32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
    endtask

    // Monitor: samples mid-cycle; a handshake there is taken at the next rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (hold_q) begin
                chk("hold_data", 32'(act_data), 32'(hold_d));
                chk("hold_idx",  32'(act_idx),  32'(hold_i));
                chk("hold_last", 32'(act_last), 32'(hold_l));
            end
            chk("frame_done", 32'(frame_done), 32'(done_exp));
            done_exp = 1'b0;
            hold_q   = 1'b0;
            if (!rst && act_valid) begin
                if (act_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_element: got idx %0d data %0h, expected none",
                                 act_idx, act_data);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("act_data", 32'(act_data), 32'(e.d));
                        chk("act_idx",  32'(act_idx),  32'(e.i));
                        chk("act_last", 32'(act_last), 32'(e.l));
                    end
                    done_exp = act_last;
                end else begin
                    hold_q = 1'b1;
                    hold_d = act_data;
                    hold_i = act_idx;
                    hold_l = act_last;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int j;
        logic [447:0] r;
        rst = 1'b1;
        in_valid = 1'b0;
        act_ready = 1'b0;
        drive_rows('0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_idle_zero("reset");
        mon_en = 1'b1;

        // Frame 1, ready high: latency and period
        act_ready = 1'b1;
        fill(16'h0100);
        send_frame();
        chk("first_valid", 32'(act_valid), 32'd1);
        chk("first_data",  32'(act_data),  32'h0100);
        chk("first_idx",   32'(act_idx),   32'd0);
        chk("busy_stream", 32'(busy),      32'd1);
        j = 0;
        while (!in_ready && j < 40) begin
            @(posedge clk); #1;
            j++;
        end
        chk("edges_to_in_ready", 32'(j), 32'd28);
        chk("done_with_in_ready", 32'(frame_done), 32'd1);

        // Frame 2, back-pressure
        act_ready = 1'b0;
        fill(16'h2200);
        send_frame();
        drain(1, 200);

        // in_valid held high with changing data during the stream
        act_ready = 1'b1;
        fill(16'h3300);
        drive_rows(pack_vals());
        push_exp();
        in_valid = 1'b1;
        @(posedge clk); #1;
        j = 0;
        while (!in_ready && j < 40) begin
            for (int w = 0; w < 14; w++) r[32*w +: 32] = $urandom;
            drive_rows(r);
            @(posedge clk); #1;
            j++;
        end
        chk("held_valid_gap", 32'(j), 32'd28);
        fill(16'h4400);
        drive_rows(pack_vals());
        push_exp();
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("second_capture_idx",  32'(act_idx),  32'd0);
        chk("second_capture_data", 32'(act_data), 32'h4400);
        drain(0, 100);

        // Reset in the middle of a frame at idx 10
        fill(16'h5500);
        send_frame();
        j = 0;
        while (act_idx != 5'd10 && j < 40) begin
            @(posedge clk); #1;
            j++;
        end
        chk("reached_idx10", 32'(act_idx), 32'd10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk_idle_zero("midreset");
        @(posedge clk); #1;
        chk("no_done_after_reset", 32'(frame_done), 32'd0);
        fill(16'h6600);
        send_frame();
        chk("restart_idx",  32'(act_idx),  32'd0);
        chk("restart_data", 32'(act_data), 32'h6600);
        drain(0, 100);

        // Sign handling: 0x8001 at idx 5, 0x7FFF at idx 6
        fill(16'h0010);
        vals[5] = 16'h8001;
        vals[6] = 16'h7FFF;
        send_frame();
        drain(1, 200);

        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fcl1_act_streamer.md
# fcl1_act_streamer

Consumer end of the pool2→FCL1 staging path. It accepts one frame of four 112-bit staged rows (`in_FCL1_1`..`in_FCL1_4`) with a valid/ready handshake. It unpacks the frame into 28 signed 16-bit activations and streams them one per handshake to the FCL1 multiply-accumulate datapath, with element index and last-element flag. It replaces free-running count-based sampling on the FCL1 side with an explicit, back-pressurable read.

## Interface
- `DW`, default 16: activation width in bits.
- `EPR`, default 7: elements per 112-bit row; row width = `DW*EPR`.
- `ROWS`, default 4: rows per frame; elements per frame `N = EPR*ROWS` = 28.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  frame on `in_FCL1_*` is stable and complete.
- `in_ready`  out  1  block can capture a frame.
- `in_FCL1_1`..`in_FCL1_4`  in  112 each  staged rows 1..4.
- `act_data`  out  `DW`  current activation, two's complement.
- `act_valid`  out  1  `act_data`/`act_idx`/`act_last` are valid.
- `act_ready`  in  1  MAC accepts current element.
- `act_idx`  out  5  element index, 0..27.
- `act_last`  out  1  high with element 27.
- `frame_done`  out  1  one-cycle pulse after element 27 is accepted.
- `busy`  out  1  high while a frame is held (state STREAM).

## Operation
- The FSM has two states: IDLE and STREAM.
- IDLE:
  - `in_ready`=1 and `act_valid`=0.
  - On `in_valid` && `in_ready`, all four rows are captured into a 448-bit frame buffer, `act_idx` is set to 0, `act_data` is loaded with element 0, and the FSM moves to STREAM.
- STREAM:
  - `in_ready`=0; `in_valid` is ignored and the buffer is not overwritten.
  - `act_valid`=1.
  - On `act_valid` && `act_ready` with `act_idx`<27: `act_idx` increments and `act_data` loads the next element.
  - On handshake with `act_idx`=27: the FSM returns to IDLE, `act_valid` drops, `frame_done` pulses for 1 cycle, and `act_idx` returns to 0.
- Element mapping:
  - Element k belongs to row r = k/7 (row 0 = `in_FCL1_1`), position p = k%7.
  - Element value = row bits [111-16p : 96-16p], i.e. MSB-first within the row.
- `act_last` = STREAM && `act_idx`==27.
- While `act_ready`=0, `act_data`, `act_idx` and `act_last` hold stable.
- No arithmetic is applied to the data except the optional clamp (see Configuration). Width stays `DW`.
- Reset:
  - All outputs are 0 except `in_ready`, which is 1 in the cycle after reset.
  - The FSM goes to IDLE and the buffer is cleared.
  - Reset mid-frame aborts the frame. No `frame_done` is issued, and the remaining elements are discarded.

## Timing
- Frame accepted at edge N → element 0 valid after edge N (visible in cycle N+1). Load latency is 1 cycle.
- With `act_ready` held high, elements 0..27 appear in consecutive cycles N+1..N+28.
- `frame_done` is high in cycle N+29, when `in_ready` is again 1.
- Minimum frame period is 29 cycles; the next frame can be accepted at the edge ending cycle N+29.
- All outputs are registered; there is no combinational path from `act_ready` or `in_valid` to any output.
- If `in_valid` and `rst` are both high in the same cycle, reset wins and nothing is captured.
- `in_valid` with `in_ready`=0 causes no state change; the upstream source must hold its data.

## Configuration
- Macro: `FCL1_RELU_EN`.
- Defined: a negative element (MSB=1) is output as 0 on `act_data`. The clamp is applied when the element is loaded into the `act_data` register, so latency is unchanged.
- Undefined: the raw signed value is passed through unchanged.
- Index, last-flag and handshake behaviour are identical in both builds.

## Test plan
- Reset, then one frame with `act_ready`=1:
  - Rows are 16-bit values where element k = 0x0100+k.
  - Required: `act_data` sequence 0x0100..0x011B in cycles N+1..N+28, `act_last` only on idx 27, `frame_done` in cycle N+29.
- Back-pressure:
  - `act_ready` toggles 1,0,0,1,...
  - Required: each element is held stable while `act_ready`=0, no element is skipped or duplicated, and the idx sequence is exactly 0..27.
- `in_valid` held high continuously with changing data:
  - Required: the second frame is captured only in cycle N+29, and the first frame's contents are unaffected.
- Reset asserted at idx 10:
  - Required: the next cycle shows `act_valid`=0, `in_ready`=1, all outputs 0, and no `frame_done`.
  - A new frame afterwards starts at idx 0.
- Element value 0x8001 at idx 5:
  - Required: output 0x0000 with `FCL1_RELU_EN` defined, 0x8001 without.
  - Positive value 0x7FFF passes unchanged in both builds.
